// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
package ifq_pkg;

    localparam int unsigned XLEN = 32;

    // One queue entry: the instruction and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] icode;
    } ifq_entry_t;

    // Position of a PC within its cache line.
    typedef struct packed {
        logic [XLEN-1:0] base;    // line-aligned byte address
        logic [XLEN-1:0] offset;  // word index within the line
    } line_pos_t;

    // Split a PC into line base and word offset for a line of fetch_width words.
    function automatic line_pos_t line_split(input logic [XLEN-1:0] pc,
                                             input int unsigned     fetch_width);
        line_pos_t       pos;
        logic [XLEN-1:0] byte_mask;
        byte_mask  = (XLEN'(fetch_width) << 2) - XLEN'(1);
        pos.base   = pc & ~byte_mask;
        pos.offset = (pc & byte_mask) >> 2;
        return pos;
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// Circular entry storage: a FETCH_WIDTH-lane masked write port that writes
// consecutive slots starting at wr_ptr, and one combinational read port.
module ifq_storage
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_WIDTH = 4,
    localparam int unsigned PW         = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic [PW-1:0]                wr_ptr,
    input  logic [FETCH_WIDTH-1:0]       wr_mask,
    input  ifq_entry_t [FETCH_WIDTH-1:0] wr_data,
    input  logic [PW-1:0]                rd_ptr,
    output ifq_entry_t                   rd_data
);

    ifq_entry_t mem [DEPTH];

    // Lane k lands at wr_ptr+k; the slot index wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (wr_mask[k]) begin
                mem[wr_ptr + PW'(k)] <= wr_data[k];
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues line-aligned I-cache requests, buffers the
// returned instructions with their PCs and presents the oldest one FWFT.
// A taken jump/branch flushes the queue and drops any in-flight line.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned FETCH_WIDTH = 4,
    parameter logic [31:0] PC_RESET    = 32'h0040_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        icache_rd_en,
    output logic [31:0]                 icache_addr,
    input  logic [32*FETCH_WIDTH-1:0]   icache_line,
    input  logic                        icache_valid,
    output logic [31:0]                 ifq_icode,
    output logic [31:0]                 ifq_pc,
    output logic                        ifq_empty,
    input  logic                        dispatch_rd,
    input  logic [31:0]                 jump_branch_add,
    input  logic                        jump_branch_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic [XLEN-1:0] fetch_pc;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   push_cnt;
    logic            outstanding;
    logic            drop;

    logic            req;
    logic            resp;
    logic            push;
    logic            pop;
    line_pos_t       lp;

    logic [XLEN-1:0]              line_words [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0]       wr_mask;
    ifq_entry_t [FETCH_WIDTH-1:0] wr_data;
    ifq_entry_t                   head;

    assign lp = line_split(fetch_pc, FETCH_WIDTH);

    // Unpack the returned line into words; word i sits at bits [32i+31:32i].
    for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_words
        assign line_words[gi] = icache_line[XLEN*gi +: XLEN];
    end

    assign req  = !outstanding
               && ((CW'(DEPTH) - count) >= CW'(FETCH_WIDTH))
               && !jump_branch_valid;
    assign resp = icache_valid && outstanding;
    assign push = resp && !drop && !jump_branch_valid;
    assign pop  = dispatch_rd && (count != '0);

    // Compact words offset..FETCH_WIDTH-1 onto lanes 0.. so storage always
    // writes a contiguous run starting at wr_ptr.
    always_comb begin
        wr_mask  = '0;
        wr_data  = '0;
        push_cnt = CW'(FETCH_WIDTH) - CW'(lp.offset);
        for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
            if (k < (FETCH_WIDTH - lp.offset)) begin
                wr_mask[k]       = push;
                wr_data[k].pc    = fetch_pc + XLEN'(k << 2);
                wr_data[k].icode = line_words[OW'(k) + lp.offset[OW-1:0]];
            end
        end
    end

    // Occupancy after this edge: a push and a pop in the same cycle both apply.
    always_comb begin
        count_next = count;
        if (push) begin
            count_next = count_next + push_cnt;
        end
        if (pop) begin
            count_next = count_next - CW'(1);
        end
    end

    // Fetch control, pointers and occupancy; a flush overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc     <= PC_RESET;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            outstanding  <= 1'b0;
            drop         <= 1'b0;
            icache_rd_en <= 1'b0;
            icache_addr  <= '0;
            ifq_empty    <= 1'b1;
        end else begin
            icache_rd_en <= req;
            if (req) begin
                icache_addr <= lp.base;
                outstanding <= 1'b1;
            end

            if (jump_branch_valid) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                ifq_empty <= 1'b1;
                fetch_pc  <= jump_branch_add & ~XLEN'(3);
                // A line returning in the flush cycle is itself the stale one,
                // so nothing is left to drop afterwards.
                if (resp) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end else begin
                    drop <= outstanding;
                end
            end else begin
                if (resp) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end
                if (push) begin
                    wr_ptr   <= wr_ptr + PW'(push_cnt);
                    fetch_pc <= lp.base + XLEN'(4 * FETCH_WIDTH);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count     <= count_next;
                ifq_empty <= (count_next == '0);
            end
        end
    end

    ifq_storage #(
        .DEPTH       (DEPTH),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_storage (
        .clk     (clk),
        .wr_ptr  (wr_ptr),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (head)
    );

    assign ifq_icode = head.icode;
    assign ifq_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed stimulus pushes expected
// requests and queue entries; a negedge monitor checks every request and pop.
module tb_instr_fetch_queue;

    logic         clk;
    logic         rst;
    logic         icache_rd_en;
    logic [31:0]  icache_addr;
    logic [127:0] icache_line;
    logic         icache_valid;
    logic [31:0]  ifq_icode;
    logic [31:0]  ifq_pc;
    logic         ifq_empty;
    logic         dispatch_rd;
    logic [31:0]  jump_branch_add;
    logic         jump_branch_valid;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] icode;
    } exp_t;

    exp_t        exp_data [$];
    logic [31:0] exp_req  [$];
    int          total   = 0;
    int          bad     = 0;
    int          req_cnt = 0;
    int          w;

    instr_fetch_queue #(
        .DEPTH       (8),
        .FETCH_WIDTH (4),
        .PC_RESET    (32'h0040_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_rd_en      (icache_rd_en),
        .icache_addr       (icache_addr),
        .icache_line       (icache_line),
        .icache_valid      (icache_valid),
        .ifq_icode         (ifq_icode),
        .ifq_pc            (ifq_pc),
        .ifq_empty         (ifq_empty),
        .dispatch_rd       (dispatch_rd),
        .jump_branch_add   (jump_branch_add),
        .jump_branch_valid (jump_branch_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] icode_of(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0000;
    endfunction

    // Monitor: every issued request and every real pop is checked in order.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (icache_rd_en) begin
                req_cnt++;
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: got=%h want=none", icache_addr);
                end else begin
                    chk("req_addr", icache_addr, exp_req.pop_front());
                end
            end
            if (dispatch_rd && !ifq_empty) begin
                if (exp_data.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got=%h want=none", ifq_pc);
                end else begin
                    e = exp_data.pop_front();
                    chk("pop_pc", ifq_pc, e.pc);
                    chk("pop_icode", ifq_icode, e.icode);
                end
            end
        end
    end

    // Wait (bounded) until the monitor has seen `target` requests in total.
    task automatic wait_req(input int target, input int max, output int waited);
        waited = 0;
        while (req_cnt < target && waited < max) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("req_arrived", 32'(req_cnt >= target), 32'd1);
    endtask

    // Present one line for a single cycle, optionally with pop and/or flush.
    task automatic send_line(input logic [31:0] base, input logic [31:0] w0,
                             input logic [31:0] w1, input logic [31:0] w2,
                             input logic [31:0] w3, input int start, input bit accept,
                             input bit with_pop, input bit with_jump,
                             input logic [31:0] jaddr);
        logic [31:0] wd [4];
        exp_t e;
        wd[0] = w0; wd[1] = w1; wd[2] = w2; wd[3] = w3;
        @(posedge clk);
        #1;
        icache_valid      = 1'b1;
        icache_line       = {w3, w2, w1, w0};
        dispatch_rd       = with_pop;
        jump_branch_valid = with_jump;
        jump_branch_add   = jaddr;
        if (accept) begin
            for (int i = start; i < 4; i++) begin
                e.pc    = base + 32'(4 * i);
                e.icode = wd[i];
                exp_data.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        icache_valid      = 1'b0;
        dispatch_rd       = 1'b0;
        jump_branch_valid = 1'b0;
    endtask

    task automatic send_gen(input logic [31:0] base, input int start, input bit accept);
        send_line(base, icode_of(base), icode_of(base + 4), icode_of(base + 8),
                  icode_of(base + 12), start, accept, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pop_n(input int n);
        @(posedge clk);
        #1;
        dispatch_rd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        dispatch_rd = 1'b0;
    endtask

    task automatic pop_until_empty();
        int i;
        i = 0;
        @(posedge clk);
        #1;
        dispatch_rd = 1'b1;
        while (!ifq_empty && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        dispatch_rd = 1'b0;
        chk("drain_done", 32'(ifq_empty), 32'd1);
    endtask

    task automatic jump(input logic [31:0] addr);
        @(posedge clk);
        #1;
        jump_branch_valid = 1'b1;
        jump_branch_add   = addr;
        @(posedge clk);
        #1;
        jump_branch_valid = 1'b0;
    endtask

    initial begin
        rst               = 1'b0;
        icache_line       = '0;
        icache_valid      = 1'b0;
        dispatch_rd       = 1'b0;
        jump_branch_add   = '0;
        jump_branch_valid = 1'b0;

        // Reset state and release
        repeat (3) @(negedge clk);
        chk("rst_rd_en", 32'(icache_rd_en), 32'd0);
        chk("rst_addr", icache_addr, 32'h0);
        chk("rst_empty", 32'(ifq_empty), 32'd1);
        exp_req.push_back(32'h0040_0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_req(1, 4, w);
        chk("first_req_lat", 32'(w), 32'd2);
        exp_req.push_back(32'h0040_0010);
        send_line(32'h0040_0000, 32'h0140_0213, 32'h01e0_0293, 32'h03c0_0313,
                  32'h0062_8233, 0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("l0_empty", 32'(ifq_empty), 32'd0);
        chk("l0_pc", ifq_pc, 32'h0040_0000);
        chk("l0_icode", ifq_icode, 32'h0140_0213);

        // Fill without pops, then free one line's worth
        wait_req(2, 4, w);
        send_gen(32'h0040_0010, 0, 1'b1);
        @(negedge clk);
        #1;
        chk("full_count", 32'(dut.count), 32'd8);
        repeat (4) @(negedge clk);
        #1;
        chk("full_no_req", 32'(req_cnt), 32'd2);
        exp_req.push_back(32'h0040_0020);
        pop_n(4);
        wait_req(3, 4, w);
        chk("req_after_pop_lat", 32'(w), 32'd2);
        send_gen(32'h0040_0020, 0, 1'b1);

        // Unaligned redirect, nothing in flight
        jump(32'h0040_0048);
        exp_data.delete();
        exp_req.push_back(32'h0040_0040);
        wait_req(4, 4, w);
        chk("redirect_req_lat", 32'(w), 32'd2);
        exp_req.push_back(32'h0040_0050);
        send_gen(32'h0040_0040, 2, 1'b1);
        @(negedge clk);
        #1;
        chk("unaligned_count", 32'(dut.count), 32'd2);
        wait_req(5, 4, w);
        exp_req.push_back(32'h0040_0060);
        send_gen(32'h0040_0050, 0, 1'b1);
        pop_n(3);
        wait_req(6, 4, w);

        // Push of 4 with a pop at count=3
        exp_req.push_back(32'h0040_0070);
        send_line(32'h0040_0060, icode_of(32'h0040_0060), icode_of(32'h0040_0064),
                  icode_of(32'h0040_0068), icode_of(32'h0040_006C), 0, 1'b1,
                  1'b1, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("push_pop_count", 32'(dut.count), 32'd6);
        pop_until_empty();
        chk("scoreboard_drained", 32'(exp_data.size()), 32'd0);
        wait_req(7, 4, w);

        // Pop while empty is ignored
        @(posedge clk);
        #1;
        dispatch_rd = 1'b1;
        @(posedge clk);
        #1;
        dispatch_rd = 1'b0;
        @(negedge clk);
        #1;
        chk("empty_pop_count", 32'(dut.count), 32'd0);
        chk("empty_pop_flag", 32'(ifq_empty), 32'd1);
        chk("empty_pop_rd_ptr", 32'(dut.rd_ptr), 32'd2);

        // Flush with a line in flight
        jump(32'h0040_0100);
        repeat (3) @(negedge clk);
        #1;
        chk("inflight_no_req", 32'(req_cnt), 32'd7);
        chk("inflight_drop", 32'(dut.drop), 32'd1);
        exp_req.push_back(32'h0040_0100);
        send_gen(32'h0040_0070, 0, 1'b0);
        @(negedge clk);
        #1;
        chk("stale_empty", 32'(ifq_empty), 32'd1);
        chk("stale_no_req_yet", 32'(icache_rd_en), 32'd0);
        wait_req(8, 3, w);
        chk("after_stale_lat", 32'(w), 32'd1);
        exp_req.push_back(32'h0040_0110);
        send_gen(32'h0040_0100, 0, 1'b1);
        wait_req(9, 4, w);

        // Flush, response and pop all in one cycle
        send_line(32'h0040_0110, icode_of(32'h0040_0110), icode_of(32'h0040_0114),
                  icode_of(32'h0040_0118), icode_of(32'h0040_011C), 0, 1'b0,
                  1'b1, 1'b1, 32'h0040_0200);
        exp_data.delete();
        exp_req.push_back(32'h0040_0200);
        @(negedge clk);
        #1;
        chk("all_count", 32'(dut.count), 32'd0);
        chk("all_empty", 32'(ifq_empty), 32'd1);
        chk("all_outstanding", 32'(dut.outstanding), 32'd0);
        chk("all_drop", 32'(dut.drop), 32'd0);

        // Mid-operation reset
        wait_req(10, 4, w);
        rst = 1'b0;
        #1;
        chk("midrst_rd_en", 32'(icache_rd_en), 32'd0);
        chk("midrst_addr", icache_addr, 32'h0);
        chk("midrst_empty", 32'(ifq_empty), 32'd1);
        chk("midrst_outstanding", 32'(dut.outstanding), 32'd0);
        chk("midrst_fetch_pc", dut.fetch_pc, 32'h0040_0000);
        @(posedge clk);
        #1;
        icache_valid = 1'b1;
        icache_line  = {4{32'hDEAD_BEEF}};
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_req.push_back(32'h0040_0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        icache_valid = 1'b0;
        wait_req(11, 4, w);
        chk("late_resp_empty", 32'(ifq_empty), 32'd1);
        chk("late_resp_count", 32'(dut.count), 32'd0);
        send_line(32'h0040_0000, 32'h0140_0213, 32'h01e0_0293, 32'h03c0_0313,
                  32'h0062_8233, 0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("rerun_empty", 32'(ifq_empty), 32'd0);
        chk("rerun_pc", ifq_pc, 32'h0040_0000);
        chk("rerun_icode", ifq_icode, 32'h0140_0213);
        chk("req_queue_used", 32'(exp_req.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction fetch queue sitting between the instruction cache and `dispatch_unit`. It generates sequential line-aligned fetch addresses, buffers up to `DEPTH` instructions with their PCs in a circular buffer, and presents the oldest one first-word-fall-through on the `ifq_icode`/`ifq_pc`/`ifq_empty`/`dispatch_rd` interface. A taken jump or branch (`jump_branch_valid`/`jump_branch_add`) flushes the queue, discards any in-flight cache line and redirects fetch.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥ `FETCH_WIDTH`.
- `FETCH_WIDTH`, 4: 32-bit words per I-cache line; power of two, ≥ 1.
- `PC_RESET`, 32'h00400000: first fetch PC after reset.

- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `icache_rd_en` out 1: one-cycle fetch request strobe.
- `icache_addr` out 32: line-aligned fetch address, valid while `icache_rd_en`=1.
- `icache_line` in 32*`FETCH_WIDTH`: returned line; word *i* at bits [32i+31:32i].
- `icache_valid` in 1: `icache_line` valid this cycle.
- `ifq_icode` out 32: head instruction.
- `ifq_pc` out 32: head PC.
- `ifq_empty` out 1: queue holds no valid entry.
- `dispatch_rd` in 1: pop head at this edge.
- `jump_branch_add` in 32: redirect target; bits [1:0] ignored.
- `jump_branch_valid` in 1: flush and redirect.

## Operation
- State: `fetch_pc` (32), `rd_ptr`/`wr_ptr` (log2 `DEPTH`), `count` (log2 `DEPTH`+1), `outstanding`, `drop`.
- Reset values: `fetch_pc`=`PC_RESET`; pointers, `count`, `outstanding` and `drop`=0; `icache_rd_en`=0; `icache_addr`=0; `ifq_empty`=1. `ifq_icode`/`ifq_pc` are don't-care while empty.
- Request condition: `!outstanding && DEPTH-count >= FETCH_WIDTH && !jump_branch_valid`. When it holds, assert `icache_rd_en` with `icache_addr` = `fetch_pc` with the low log2(`FETCH_WIDTH`)+2 bits cleared, then set `outstanding`. At most one request is in flight.
- Response (`icache_valid`=1 with `outstanding`):
  - If `drop`=1: discard the line and clear `drop` and `outstanding`.
  - Otherwise: offset = `fetch_pc`[log2(`FETCH_WIDTH`)+1:2]. Enqueue words offset..`FETCH_WIDTH`-1 in order with PCs `fetch_pc`, `fetch_pc`+4, …. Add `FETCH_WIDTH`-offset to `count`. Set `fetch_pc` to line base + 4·`FETCH_WIDTH`. Clear `outstanding`.
- Pop: `dispatch_rd`=1 with `count`>0 advances `rd_ptr` and decrements `count`. `dispatch_rd` while empty is ignored.
- Push and pop in the same cycle are both applied (net count change = pushed − 1). Overflow is impossible because free space is checked at request time and pops only add space.
- Flush (`jump_branch_valid`=1) has priority over push and pop:
  - pointers and `count` go to 0;
  - `fetch_pc` = `jump_branch_add` & ~3;
  - `drop` = `outstanding`;
  - if `icache_valid` is high in the same cycle, that line is discarded and `outstanding`/`drop` are cleared.
- Pointers wrap modulo `DEPTH`. PC arithmetic is 32-bit and wraps silently.
- `icache_valid` without `outstanding` is ignored.

## Timing
- FWFT: `ifq_icode`/`ifq_pc` reflect the `rd_ptr` entry combinationally from registered storage. `ifq_empty` = (`count`==0) is registered state.
- Fetch-to-visible latency: a line captured at edge N is visible with `ifq_empty`=0 after edge N.
- First request goes out in the first cycle after `rst` deasserts.
- After a flush with nothing in flight, the new request goes out in the next cycle.
- After a flush with a line in flight, the new request goes out in the cycle after the stale line returns.
- Minimum throughput: one line per request round-trip.
- Asserting `rst` mid-operation clears all state immediately and asynchronously; a response arriving later is ignored because `outstanding`=0.

## Structure
- `ifq_pkg`: `XLEN`=32, the `ifq_entry_t` struct {pc, icode}, and a function returning the line base and offset for a given `FETCH_WIDTH`.
- One sub-module, `ifq_storage`: a `DEPTH`×`ifq_entry_t` register array with a `FETCH_WIDTH`-wide masked write port and one read port. Pointers, count and fetch control stay in `instr_fetch_queue`.

## Test plan
- **Reset release**, DEPTH=8, FW=4, `rst` high: `icache_rd_en`=1 with addr 0x00400000. Return the line {0x01400213, 0x01e00293, 0x03c00313, 0x00628233} → next cycle `ifq_empty`=0, `ifq_pc`=0x00400000, `ifq_icode`=0x01400213.
- **Fill without pops**: after lines 0x00400000 and 0x00400010, `count`=8 and no further request. Pop 4 → request 0x00400020 in the following cycle. Head PCs advance by 4 per pop.
- **Unaligned redirect**: `jump_branch_add`=0x00400048 → request 0x00400040. Only words 2 and 3 are enqueued, with PCs 0x00400048 and 0x0040004C; `count`=2. Next request is 0x00400050.
- **Flush with line in flight**: raise `jump_branch_valid` one cycle after the request → the stale line is discarded and `ifq_empty` stays 1. The new request to the target goes out the cycle after the stale response.
- **Simultaneous events**: push of 4 plus pop at `count`=3 → `count`=6. `dispatch_rd` with `ifq_empty`=1 → no change. `jump_branch_valid`, `icache_valid` and `dispatch_rd` all at once → `count`=0 and the line is discarded.
- **Mid-operation reset**: pull `rst` low while `outstanding`=1 → all outputs return to reset values at once. The late `icache_valid` is ignored, and the first request after release is 0x00400000.
